split_n_dispatch: RTL

Clocked, parametrised fan-out dispatcher for the four-phase req/ack pipeline. It accepts one token from a single producer and forwards it to any subset of N_OUT consumer channels selected by a route mask: one-hot for ordinary dispatch, several bits for multicast. Channels complete their handshakes independently; the producer is acknowledged once every selected channel has acknowledged. It sits between the instruction-class decoder and the execution/memory/branch stages, and additionally provides sticky error flags and a token counter.

---
 rtl/split_n_dispatch.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/split_n_dispatch.sv
// split_n_dispatch
//   Fan-out dispatcher for a four-phase req/ack pipeline. One token from a
//   single producer is latched and offered to every consumer channel selected
//   by the route mask (one-hot = dispatch, several bits = multicast). Each
//   channel retires independently. The producer is acknowledged once all
//   selected channels have acknowledged. Also keeps two sticky error flags and
//   a count of completed tokens.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   req_in    producer request
//   route     channel select mask, sampled with req_in in IDLE
//   data_in   payload, sampled with req_in in IDLE
//   ack_out   producer acknowledge
//   req_out   per-channel request
//   data_out  latched payload, shared by all channels
//   ack_in    per-channel acknowledge
//   clr_err   synchronous clear of err_drop / err_ack
//   err_drop  sticky: token arrived with an empty route
//   err_ack   sticky: ack_in[i] rose while channel i was not pending
//   tok_cnt   completed tokens with a nonzero route, wrapping

module split_n_dispatch #(
    parameter int N_OUT  = 3,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_in,
    input  logic [N_OUT-1:0]  route,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_out,
    output logic [N_OUT-1:0]  req_out,
    output logic [DATA_W-1:0] data_out,
    input  logic [N_OUT-1:0]  ack_in,
    input  logic              clr_err,
    output logic              err_drop,
    output logic              err_ack,
    output logic [CNT_W-1:0]  tok_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        RELEASE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [N_OUT-1:0]    route_q, route_d;
    // Pending channels. A channel's request is asserted exactly while it is
    // pending, so this register drives req_out directly.
    logic [N_OUT-1:0]    pend_q, pend_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                ack_q, ack_d;
    logic                err_drop_q, err_drop_d;
    logic                err_ack_q, err_ack_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_OUT-1:0]    ack_in_q;

    logic                drop_set;
    logic                ack_set;
    logic [N_OUT-1:0]    ack_rise;

    // A rising acknowledge on a channel that is not waiting for one is a
    // consumer protocol error.
    assign ack_rise = ack_in & ~ack_in_q;
    assign ack_set  = |(ack_rise & ~pend_q);

    always_comb begin
        state_d  = state_q;
        route_d  = route_q;
        pend_d   = pend_q;
        data_d   = data_q;
        ack_d    = ack_q;
        cnt_d    = cnt_q;
        drop_set = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_in) begin
                    if (|route) begin
                        route_d = route;
                        pend_d  = route;
                        data_d  = data_in;
                        state_d = DISPATCH;
                    end else begin
                        // Empty route: acknowledge at once and drop the token.
                        route_d  = '0;
                        ack_d    = 1'b1;
                        drop_set = 1'b1;
                        state_d  = RELEASE;
                    end
                end
            end
            DISPATCH: begin
                pend_d = pend_q & ~ack_in;
                // Acknowledge the producer on the same edge the last
                // pending channel retires.
                if (pend_d == '0) begin
                    ack_d   = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!req_in && ((ack_in & route_q) == '0)) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                    if (route_q != '0)
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = '0;
                ack_d   = 1'b0;
            end
        endcase

        // Set beats clear when both happen on the same edge.
        err_drop_d = drop_set ? 1'b1 : (clr_err ? 1'b0 : err_drop_q);
        err_ack_d  = ack_set  ? 1'b1 : (clr_err ? 1'b0 : err_ack_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            route_q    <= '0;
            pend_q     <= '0;
            data_q     <= '0;
            ack_q      <= 1'b0;
            err_drop_q <= 1'b0;
            err_ack_q  <= 1'b0;
            cnt_q      <= '0;
            ack_in_q   <= '0;
        end else begin
            state_q    <= state_d;
            route_q    <= route_d;
            pend_q     <= pend_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            err_drop_q <= err_drop_d;
            err_ack_q  <= err_ack_d;
            cnt_q      <= cnt_d;
            ack_in_q   <= ack_in;
        end
    end

    assign ack_out  = ack_q;
    assign req_out  = pend_q;
    assign data_out = data_q;
    assign err_drop = err_drop_q;
    assign err_ack  = err_ack_q;
    assign tok_cnt  = cnt_q;

endmodule
